// File: rtl/tone_pkg.sv
// tone_pkg: shared types and constants for the buzzer tone path.
//   state_e        : tone_gen controller states (IDLE, DIV, PLAY)
//   CLK_HZ_DEFAULT : default system clock in Hz
//   NOTE_*         : note frequencies in Hz, shared with the melody ROMs
package tone_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    PLAY = 2'd2
  } state_e;

  localparam int CLK_HZ_DEFAULT = 100_000_000;

  localparam int unsigned NOTE_C4 = 262;
  localparam int unsigned NOTE_D4 = 294;
  localparam int unsigned NOTE_E4 = 330;
  localparam int unsigned NOTE_F4 = 349;
  localparam int unsigned NOTE_G4 = 392;
  localparam int unsigned NOTE_A4 = 440;
  localparam int unsigned NOTE_B4 = 494;
  localparam int unsigned NOTE_C5 = 523;

endpackage

// File: rtl/seq_divider.sv
// seq_divider: restoring unsigned divider, one quotient bit per cycle.
//   clk, rst  : clock, asynchronous active-low reset
//   start     : load dividend/divisor; the first bit is resolved on this edge
//   dividend  : W-bit numerator
//   divisor   : W-bit denominator (must be non-zero)
//   done      : one-cycle pulse, quotient valid while high and held after
//   quotient  : W-bit result; the remainder is discarded
// Latency is fixed: done is high in the W-th cycle after the start cycle.
module seq_divider #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         done,
  output logic [W-1:0] quotient
);

  localparam int CW = $clog2(W) + 1;

  logic [W-1:0]  rem_q, quo_q, dsr_q;
  logic [CW-1:0] left_q;
  logic          run_q, done_q;

  logic [W-1:0]  rem_src, quo_src, dsr_src, rem_nx, quo_nx;
  logic [W:0]    trial;

  // The start edge feeds the step straight from the ports so the whole
  // divide takes exactly W edges.
  always_comb begin
    if (start) begin
      rem_src = '0;
      quo_src = dividend;
      dsr_src = divisor;
    end else begin
      rem_src = rem_q;
      quo_src = quo_q;
      dsr_src = dsr_q;
    end
    trial = {rem_src, quo_src[W-1]};
    if (trial >= {1'b0, dsr_src}) begin
      rem_nx = W'(trial - {1'b0, dsr_src});
      quo_nx = {quo_src[W-2:0], 1'b1};
    end else begin
      rem_nx = trial[W-1:0];
      quo_nx = {quo_src[W-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dsr_q  <= '0;
      left_q <= '0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        rem_q  <= rem_nx;
        quo_q  <= quo_nx;
        dsr_q  <= divisor;
        left_q <= CW'(W - 1);
        run_q  <= 1'b1;
      end else if (run_q) begin
        rem_q  <= rem_nx;
        quo_q  <= quo_nx;
        left_q <= left_q - CW'(1);
        if (left_q == CW'(1)) begin
          run_q  <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign done     = done_q;
  assign quotient = quo_q;

endmodule

// File: rtl/tone_gen.sv
// tone_gen: converts a note frequency in Hz into a square/PWM buzzer drive.
//   clk    : system clock (CLK_HZ)
//   rst    : asynchronous active-low reset
//   freq   : requested tone in Hz, 0 = silence, > CLK_HZ/2 treated as 0
//   mute   : forces audio low combinationally; timing is unaffected
//   vol    : (TONE_VOLUME_EN only) duty select, high_time = period >> (vol+1)
//   audio  : buzzer drive
//   busy   : high while the period divider runs
//   period : current period in clk cycles, 0 when idle
// Optional feature macro: TONE_VOLUME_EN (adds vol; otherwise duty is 50%).
// New frequencies and vol are only taken at period boundaries.
module tone_gen
  import tone_pkg::*;
#(
  parameter int CLK_HZ = CLK_HZ_DEFAULT,
  parameter int FREQ_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [FREQ_W-1:0] freq,
  input  logic              mute,
`ifdef TONE_VOLUME_EN
  input  logic [1:0]        vol,
`endif
  output logic              audio,
  output logic              busy,
  output logic [FREQ_W-1:0] period
);

  localparam logic [FREQ_W-1:0] HALF_HZ  = FREQ_W'(CLK_HZ / 2);
  localparam logic [FREQ_W-1:0] DIVIDEND = FREQ_W'(CLK_HZ);

  state_e            state_q, state_d;
  logic [FREQ_W-1:0] f_lat_q, f_lat_d;
  logic [FREQ_W-1:0] cnt_q, cnt_d;
  logic [FREQ_W-1:0] period_q, period_d;
  logic [FREQ_W-1:0] high_q, high_d;
  logic              busy_q, pwm_q, pwm_d;

  logic              freq_ok, at_end;
  logic              div_start, div_done;
  logic [FREQ_W-1:0] div_quo;
  logic [2:0]        shamt;

`ifdef TONE_VOLUME_EN
  assign shamt = {1'b0, vol} + 3'd1;
`else
  assign shamt = 3'd1;
`endif

  assign freq_ok = (freq != '0) && (freq <= HALF_HZ);
  assign at_end  = (cnt_q == period_q - FREQ_W'(1));

  seq_divider #(.W(FREQ_W)) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .dividend (DIVIDEND),
    .divisor  (f_lat_d),
    .done     (div_done),
    .quotient (div_quo)
  );

  // high_q holds the duty threshold for the running period; it is refreshed
  // only when a period starts so vol changes never split a period.
  always_comb begin
    state_d   = state_q;
    f_lat_d   = f_lat_q;
    cnt_d     = cnt_q;
    period_d  = period_q;
    high_d    = high_q;
    div_start = 1'b0;
    pwm_d     = (state_q == PLAY) && (cnt_q < high_q);
    case (state_q)
      IDLE: begin
        if (freq_ok) begin
          f_lat_d   = freq;
          div_start = 1'b1;
          state_d   = DIV;
        end
      end
      DIV: begin
        if (div_done) begin
          period_d = div_quo;
          high_d   = div_quo >> shamt;
          cnt_d    = '0;
          state_d  = PLAY;
        end
      end
      PLAY: begin
        if (at_end) begin
          if (freq == f_lat_q) begin
            cnt_d  = '0;
            high_d = period_q >> shamt;
          end else if (freq_ok) begin
            f_lat_d   = freq;
            div_start = 1'b1;
            state_d   = DIV;
          end else begin
            cnt_d    = '0;
            period_d = '0;
            high_d   = '0;
            state_d  = IDLE;
          end
        end else begin
          cnt_d = cnt_q + FREQ_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      f_lat_q  <= '0;
      cnt_q    <= '0;
      period_q <= '0;
      high_q   <= '0;
      busy_q   <= 1'b0;
      pwm_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      f_lat_q  <= f_lat_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      high_q   <= high_d;
      busy_q   <= (state_d == DIV);
      pwm_q    <= pwm_d;
    end
  end

  assign audio  = pwm_q & ~mute;
  assign busy   = busy_q;
  assign period = period_q;

endmodule

// File: tb/tb_tone_gen.sv
module tb_tone_gen;

  localparam int CLK_HZ  = 1000;
  localparam int FREQ_W  = 32;
  localparam int DIV_CYC = 32;

  logic              clk = 1'b0;
  logic              rst, mute, audio, busy;
  logic [FREQ_W-1:0] freq, period;
`ifdef TONE_VOLUME_EN
  logic [1:0]        vol;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  tone_gen #(.CLK_HZ(CLK_HZ), .FREQ_W(FREQ_W)) dut (
    .clk    (clk),
    .rst    (rst),
    .freq   (freq),
    .mute   (mute),
`ifdef TONE_VOLUME_EN
    .vol    (vol),
`endif
    .audio  (audio),
    .busy   (busy),
    .period (period)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model + scoreboard ----------------
  typedef struct {
    bit     a;
    bit     b;
    longint p;
  } exp_t;
  exp_t sb[$];

  // mode: 0 silent, 1 computing the period, 2 sounding
  int     m_mode = 0;
  int     m_left = 0;
  longint m_f = 0, m_per = 0, m_pos = 0, m_high = 0;
  bit     m_pwm = 0;

  function automatic bit playable(input longint f);
    return (f != 0) && (f <= CLK_HZ / 2);
  endfunction

  function automatic longint duty_high(input longint per);
    int k;
`ifdef TONE_VOLUME_EN
    k = int'(vol) + 1;
`else
    k = 1;
`endif
    return per / (2 ** k);
  endfunction

  initial begin
    bit     nxt_pwm;
    longint f;
    forever begin
      @(posedge clk);
      if (!rst) begin
        m_mode = 0; m_per = 0; m_pos = 0; m_high = 0; m_f = 0; m_pwm = 0;
      end else begin
        f       = longint'(freq);
        nxt_pwm = (m_mode == 2) && (m_pos < m_high);
        case (m_mode)
          0: if (playable(f)) begin
               m_f = f; m_mode = 1; m_left = DIV_CYC;
             end
          1: begin
               m_left--;
               if (m_left == 0) begin
                 m_per  = CLK_HZ / m_f;
                 m_pos  = 0;
                 m_high = duty_high(m_per);
                 m_mode = 2;
               end
             end
          default: begin
            if (m_pos == m_per - 1) begin
              if (f == m_f) begin
                m_pos  = 0;
                m_high = duty_high(m_per);
              end else if (playable(f)) begin
                m_f = f; m_mode = 1; m_left = DIV_CYC;
              end else begin
                m_mode = 0; m_per = 0;
              end
            end else begin
              m_pos++;
            end
          end
        endcase
        m_pwm = nxt_pwm;
      end
      sb.push_back('{m_pwm, (m_mode == 1), m_per});
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL scoreboard_empty at %0t: got no expected entry, required one", $time);
      end else begin
        e = sb.pop_front();
        if (!rst) e = '{0, 0, 0};
        chk("audio",  longint'(audio),  longint'(e.a && !mute));
        chk("busy",   longint'(busy),   longint'(e.b));
        chk("period", longint'(period), e.p);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic count_high(input int n, output int c);
    c = 0;
    repeat (n) begin
      @(negedge clk);
      c += int'(audio);
    end
  endtask

  task automatic count_busy(input int n, output int c);
    c = 0;
    repeat (n) begin
      @(negedge clk);
      c += int'(busy);
    end
  endtask

  task automatic wait_rise(input int budget);
    bit prev;
    bit seen;
    prev = audio;
    seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (!prev && audio) seen = 1;
      prev = audio;
    end
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_rise at %0t: no audio rising edge within %0d cycles", $time, budget);
    end
  endtask

  function automatic logic [FREQ_W-1:0] pick_freq();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return FREQ_W'(100);
      2:       return FREQ_W'(200);
      3:       return FREQ_W'(500);
      4:       return FREQ_W'(501);
      5:       return FREQ_W'(3);
      6:       return FREQ_W'(250);
      default: return FREQ_W'($urandom_range(1, 600));
    endcase
  endfunction

  // ---------------- directed + random stimulus ----------------
  initial begin
    int c;
    rst  = 1'b0;
    freq = '0;
    mute = 1'b0;
`ifdef TONE_VOLUME_EN
    vol  = 2'd0;
`endif
    tick(3);
    rst  = 1'b1;
    freq = FREQ_W'(100);
    tick(50);

    // asynchronous reset during a high phase
    wait_rise(40);
    #2 rst = 1'b0;
    #1;
    chk("rst_audio",  longint'(audio),  0);
    chk("rst_busy",   longint'(busy),   0);
    chk("rst_period", longint'(period), 0);
    tick(2);
    rst = 1'b1;
    count_busy(40, c);
    chk("busy_cycles_f100", c, 32);
    chk("period_f100", longint'(period), 10);
    count_high(20, c);
    chk("high_f100", c, 10);

    // long period, 166 of 333 high
    tick(1);
    freq = FREQ_W'(3);
    tick(60);
    chk("period_f3", longint'(period), 333);
    count_high(999, c);
    chk("high_f3", c, 498);

    // back to 100, then change to 200 mid-period
    tick(1);
    freq = FREQ_W'(100);
    tick(400);
    chk("period_back_f100", longint'(period), 10);
    wait_rise(20);
    tick(2);
    freq = FREQ_W'(200);
    tick(60);
    chk("period_f200", longint'(period), 5);
    count_high(10, c);
    chk("high_f200", c, 4);

    // mute for 3 cycles inside a high phase
    tick(1);
    freq = FREQ_W'(100);
    tick(60);
    wait_rise(20);
    tick(1);
    mute = 1'b1;
    tick(3);
    mute = 1'b0;
    count_high(10, c);
    chk("high_after_mute", c, 5);

    // silence, then an out-of-range request
    tick(1);
    freq = '0;
    tick(15);
    chk("period_silent", longint'(period), 0);
    chk("busy_silent",   longint'(busy),   0);
    freq = FREQ_W'(600);
    count_busy(40, c);
    chk("busy_f600", c, 0);
    chk("period_f600", longint'(period), 0);

`ifdef TONE_VOLUME_EN
    tick(1);
    freq = FREQ_W'(100);
    tick(60);
    for (int v = 0; v < 4; v++) begin
      int want;
      vol = 2'(v);
      tick(25);
      count_high(10, c);
      want = (v == 0) ? 5 : (v == 1) ? 2 : (v == 2) ? 1 : 0;
      chk("high_vol", c, want);
    end
    tick(1);
    vol = 2'd0;
`endif

    // randomized phase, checked cycle by cycle through the scoreboard
    for (int i = 0; i < 3000; i++) begin
      tick(1);
      if ($urandom_range(0, 39) == 0) freq = pick_freq();
      if ($urandom_range(0, 29) == 0) mute = ~mute;
`ifdef TONE_VOLUME_EN
      if ($urandom_range(0, 49) == 0) vol = 2'($urandom_range(0, 3));
`endif
    end
    mute = 1'b0;
    tick(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tone_gen.md
Name: tone_gen

Overview:
- Downstream consumer of the music frequency selector's `freq` output.
- Converts a requested note frequency in Hz into a square/PWM audio drive for the board buzzer.
- Derives the period with an internal sequential divider.
- Applies frequency changes only at period boundaries, so each note boundary is glitch-free.

Parameters:
- CLK_HZ, 100_000_000: system clock frequency in Hz; the dividend for the period computation.
- FREQ_W, 32: width of the freq input and of the period/counter registers.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-low reset
- freq  input  FREQ_W  requested tone in Hz; 0 = silence
- mute  input  1  forces audio low immediately; timing continues
- audio  output  1  buzzer drive
- busy  output  1  high while the divider is running
- period  output  FREQ_W  current period in clk cycles; 0 when idle

Behaviour:
- Reset (rst low, asynchronous):
  - state = IDLE.
  - audio = 0, busy = 0, period = 0.
  - Counter, latched frequency and divider registers cleared.
- State IDLE:
  - audio = 0.
  - If freq != 0 and freq <= CLK_HZ/2: latch freq into f_lat, start the divider, go to DIV.
  - Out-of-range freq is treated as 0 and the block stays in IDLE.
- State DIV:
  - busy = 1, audio = 0.
  - Restoring divide of CLK_HZ by f_lat, one quotient bit per cycle, exactly FREQ_W cycles; the remainder is discarded.
  - On done: period <= quotient, cnt <= 0, go to PLAY.
  - The first audio high appears on the cycle after entry to PLAY, FREQ_W+1 cycles after the latching edge.
- State PLAY:
  - cnt increments every cycle, 0..period-1.
  - high_time = period >> 1 (50% duty).
  - audio = (cnt < high_time) && !mute.
- Period boundary, at cnt == period-1 (all freq range checks use the same rule as IDLE):
  - freq == f_lat: cnt wraps to 0.
  - freq differs and is valid: latch the new freq, go to DIV.
  - freq is 0 or out of range: go to IDLE, period <= 0.
  - freq changes mid-period have no effect until the boundary.
- mute is combinational on audio only; it never alters state, cnt or period.
- busy is registered and equals (state == DIV).
- freq toggling during DIV is ignored; the next check is at the first PLAY boundary.
- Minimum period is 2 (freq = CLK_HZ/2), giving high_time = 1.

Optional Feature:
- Macro: TONE_VOLUME_EN.
- When defined:
  - Extra port vol, input, 2 bits.
  - high_time = period >> (vol + 1), giving duty 50/25/12.5/6.25%.
  - vol is sampled at each period boundary only.
  - If the shifted high_time is 0, audio stays low for that period.
- When undefined: no vol port; duty is fixed at 50%.

Decomposition:
- Package tone_pkg:
  - State enum (IDLE, DIV, PLAY).
  - Default CLK_HZ constant.
  - Scene-independent note frequency constants (C4 = 262, etc.) shared with the melody ROMs.
- Sub-module seq_divider:
  - Parameterised restoring divider.
  - Ports: start, dividend, divisor, done, quotient; fixed FREQ_W-cycle latency.
  - Independently testable.

Test Plan (bench overrides CLK_HZ = 1000, FREQ_W = 32):
- Reset mid-PLAY with freq = 100 → audio, busy and period return to 0 asynchronously. After release with freq = 100: busy high for 32 cycles, period = 10, audio 5 high / 5 low repeating.
- freq = 3 → period = 333, high_time = 166. Over three periods, audio is high exactly 166 of every 333 cycles.
- Change freq 100 → 200 at cnt = 3 → the current 10-cycle period completes intact, then DIV runs 32 cycles, then period = 5 and high = 2.
- freq → 0 mid-PLAY → audio finishes the current period, then IDLE with period = 0. freq = 600 (> CLK_HZ/2) from IDLE → remains IDLE, busy never asserts.
- mute pulsed for 3 cycles during a high phase → audio low exactly those 3 cycles, and cnt/period sequence unchanged.
- With TONE_VOLUME_EN, freq = 100:
  - vol = 0 → 5 high per 10.
  - vol = 1 → 2 high.
  - vol = 2 → 1 high.
  - vol = 3 → 0 high, audio constantly low.
  - A vol change mid-period takes effect at the next boundary.
